// File: rtl/aftab_memory_arbiter.sv
// ----------------------------------------------------------------------------
// aftab_memory_arbiter
//
// Two-port arbiter and access sequencer placed in front of a single
// aftab_memory_segment. Port 0 carries instruction fetches and port 1 carries
// data accesses from the AFTAB core. One requester is granted at a time,
// using round-robin priority. The winning access is registered onto the
// segment bus. The segment's memDataReady completes the access, and a
// timeout with a bus-error pulse recovers from a segment that never answers.
//
// Sequence per access: IDLE -> ACCESS (strobe held) -> RELEASE -> IDLE.
// With a zero-wait segment this takes 3 cycles per access.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   readMemN, writeMemN   port N request (both high = write), held until
//                         memReadyN or busErrorN
//   addressN, dataInN     port N address / write data, stable while requesting
//   dataOutN              port N registered read data
//   memReadyN, busErrorN  port N one-cycle completion / timeout pulses
//   readmem, writemem     strobes to the segment
//   addressBus            address to the segment
//   memDataOut            write data to the segment (its dataBusIn)
//   memDataIn             read data from the segment (its dataBusOut)
//   memDataReady          segment completion
//   grant                 one-hot owner of the current access, 00 when idle
//   busy                  high while in ACCESS or RELEASE
//
// timeoutCycles: number of ACCESS or RELEASE cycles before a forced release.
// The legal range is 2..65535.
// ----------------------------------------------------------------------------
module aftab_memory_arbiter #(
    parameter int dataWidth     = 8,
    parameter int addressWidth  = 32,
    parameter int timeoutCycles = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    readMem0,
    input  logic                    writeMem0,
    input  logic [addressWidth-1:0] address0,
    input  logic [dataWidth-1:0]    dataIn0,
    output logic [dataWidth-1:0]    dataOut0,
    output logic                    memReady0,
    output logic                    busError0,

    input  logic                    readMem1,
    input  logic                    writeMem1,
    input  logic [addressWidth-1:0] address1,
    input  logic [dataWidth-1:0]    dataIn1,
    output logic [dataWidth-1:0]    dataOut1,
    output logic                    memReady1,
    output logic                    busError1,

    output logic                    readmem,
    output logic                    writemem,
    output logic [addressWidth-1:0] addressBus,
    output logic [dataWidth-1:0]    memDataOut,
    input  logic [dataWidth-1:0]    memDataIn,
    input  logic                    memDataReady,

    output logic [1:0]              grant,
    output logic                    busy
);

    typedef enum logic [1:0] {
        st_idle    = 2'd0,
        st_access  = 2'd1,
        st_release = 2'd2
    } state_t;

    // The counter only has to reach timeoutCycles-1.
    localparam int cnt_w = (timeoutCycles > 2) ? $clog2(timeoutCycles) : 1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeoutCycles - 1);

    state_t                  state;
    state_t                  next_state;
    logic                    last_grant;   // port served most recently
    logic [cnt_w-1:0]        cnt;
    logic                    cnt_expired;

    logic                    req0;
    logic                    req1;

    logic                    win_port;
    logic                    win_write;
    logic [addressWidth-1:0] win_addr;
    logic [dataWidth-1:0]    win_data;

    logic                    do_grant;     // IDLE -> ACCESS
    logic                    do_done;      // ACCESS -> RELEASE, segment answered
    logic                    do_timeout;   // ACCESS -> RELEASE, no answer
    logic                    do_release;   // RELEASE -> IDLE

    assign req0        = readMem0 | writeMem0;
    assign req1        = readMem1 | writeMem1;
    assign cnt_expired = (cnt == cnt_last);
    assign busy        = (state != st_idle);

    // ------------------------------------------------------------------------
    // Next-state and decision logic
    // ------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case statement.
    // Otherwise a path that skips the assignment would infer a latch.
    always_comb begin
        next_state = state;
        win_port   = 1'b0;
        do_grant   = 1'b0;
        do_done    = 1'b0;
        do_timeout = 1'b0;
        do_release = 1'b0;

        unique case (state)
            st_idle: begin
                if (req0 && req1) begin
                    // Tie: the port that was not served last wins.
                    win_port = ~last_grant;
                    do_grant = 1'b1;
                end else if (req0) begin
                    win_port = 1'b0;
                    do_grant = 1'b1;
                end else if (req1) begin
                    win_port = 1'b1;
                    do_grant = 1'b1;
                end
                if (do_grant) next_state = st_access;
            end

            st_access: begin
                // A ready on the last counted cycle still counts as success.
                if (memDataReady) begin
                    do_done    = 1'b1;
                    next_state = st_release;
                end else if (cnt_expired) begin
                    do_timeout = 1'b1;
                    next_state = st_release;
                end
            end

            st_release: begin
                // Requests are ignored here. A requester drops its request
                // on the cycle after its pulse, and IDLE only looks at
                // requests once that has happened.
                if (!memDataReady || cnt_expired) begin
                    do_release = 1'b1;
                    next_state = st_idle;
                end
            end

            default: begin
                next_state = st_idle;
            end
        endcase
    end

    // Select the winner's request. A request with both strobes high is a write.
    always_comb begin
        win_write = writeMem0;
        win_addr  = address0;
        win_data  = dataIn0;
        if (win_port) begin
            win_write = writeMem1;
            win_addr  = address1;
            win_data  = dataIn1;
        end
    end

    // ------------------------------------------------------------------------
    // State register, round-robin memory and timeout counter
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from the pre-edge values, with no ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= st_idle;
            last_grant <= 1'b1;        // port 0 wins the first tie
            cnt        <= '0;
        end else begin
            state <= next_state;
            if (do_grant) last_grant <= win_port;

            if (do_grant || do_done || do_timeout || do_release)
                cnt <= '0;
            else if (state != st_idle)
                cnt <= cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registered segment bus, grant, read data and port pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readmem    <= 1'b0;
            writemem   <= 1'b0;
            addressBus <= '0;
            memDataOut <= '0;
            grant      <= 2'b00;
            dataOut0   <= '0;
            dataOut1   <= '0;
            memReady0  <= 1'b0;
            memReady1  <= 1'b0;
            busError0  <= 1'b0;
            busError1  <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            memReady0 <= 1'b0;
            memReady1 <= 1'b0;
            busError0 <= 1'b0;
            busError1 <= 1'b0;

            if (do_grant) begin
                addressBus <= win_addr;
                memDataOut <= win_data;
                writemem   <= win_write;
                readmem    <= ~win_write;
                grant      <= {win_port, ~win_port};
            end

            if (do_done) begin
                readmem   <= 1'b0;
                writemem  <= 1'b0;
                memReady0 <= grant[0];
                memReady1 <= grant[1];
                // memDataIn is only meaningful during a read. Writes leave
                // dataOut alone.
                if (readmem && grant[0]) dataOut0 <= memDataIn;
                if (readmem && grant[1]) dataOut1 <= memDataIn;
            end

            if (do_timeout) begin
                readmem   <= 1'b0;
                writemem  <= 1'b0;
                busError0 <= grant[0];
                busError1 <= grant[1];
            end

            // addressBus and memDataOut keep their last value while idle.
            if (do_release) grant <= 2'b00;
        end
    end

    // ------------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------------
    a_pulse_excl: assert property (@(posedge clk) disable iff (rst)
        !((memReady0 && busError0) || (memReady1 && busError1)));

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        grant != 2'b11);

    a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
        !(readmem && writemem));

endmodule

// File: tb/tb_aftab_memory_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for aftab_memory_arbiter.
// A behavioural segment (256-byte array, random wait states, addresses at
// 0x100 and above unselected) sits on the segment side. Directed sequences
// cover the latency and boundary cases. Two random requesters then run
// against a transaction-level memory model, and a per-cycle monitor checks
// the bus invariants and the round-robin fairness.
// ----------------------------------------------------------------------------
module tb_aftab_memory_arbiter;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;

    logic          readMem0, writeMem0, readMem1, writeMem1;
    logic [AW-1:0] address0, address1;
    logic [DW-1:0] dataIn0, dataIn1, dataOut0, dataOut1;
    logic          memReady0, busError0, memReady1, busError1;
    logic          readmem, writemem;
    logic [AW-1:0] addressBus;
    logic [DW-1:0] memDataOut, memDataIn;
    logic          memDataReady;
    logic [1:0]    grant;
    logic          busy;

    aftab_memory_arbiter #(
        .dataWidth    (DW),
        .addressWidth (AW),
        .timeoutCycles(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .readMem0    (readMem0),
        .writeMem0   (writeMem0),
        .address0    (address0),
        .dataIn0     (dataIn0),
        .dataOut0    (dataOut0),
        .memReady0   (memReady0),
        .busError0   (busError0),
        .readMem1    (readMem1),
        .writeMem1   (writeMem1),
        .address1    (address1),
        .dataIn1     (dataIn1),
        .dataOut1    (dataOut1),
        .memReady1   (memReady1),
        .busError1   (busError1),
        .readmem     (readmem),
        .writemem    (writemem),
        .addressBus  (addressBus),
        .memDataOut  (memDataOut),
        .memDataIn   (memDataIn),
        .memDataReady(memDataReady),
        .grant       (grant),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Comparison bookkeeping
    // ------------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural memory segment
    // ------------------------------------------------------------------------
    logic [DW-1:0] seg_mem [256];
    int            seg_cnt     = 0;
    int            seg_wait    = 0;
    int            max_wait    = 0;
    logic          stuck_ready = 1'b0;
    logic          seg_cs;

    assign seg_cs       = (addressBus < 32'd256);
    assign memDataReady = stuck_ready ||
                          ((readmem || writemem) && seg_cs && (seg_cnt >= seg_wait));
    assign memDataIn    = (readmem && seg_cs) ? seg_mem[addressBus[7:0]] : 8'hEE;

    always @(posedge clk) begin
        if (writemem && seg_cs && memDataReady) seg_mem[addressBus[7:0]] <= memDataOut;
        if (readmem || writemem) begin
            seg_cnt <= seg_cnt + 1;
        end else begin
            seg_cnt  <= 0;
            seg_wait <= int'($urandom_range(0, max_wait));
        end
    end

    // ------------------------------------------------------------------------
    // Reference model: memory contents and each port's last read data
    // ------------------------------------------------------------------------
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_dout [2];

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 'h10) ? 8'hA5 : 8'(i * 7 + 19);
    endfunction

    // ------------------------------------------------------------------------
    // Per-cycle monitor: invariants and round-robin fairness
    // ------------------------------------------------------------------------
    logic [1:0] req_edge = 2'b00;
    logic [1:0] mon_prev_grant = 2'b00;
    int         skip [2] = '{0, 0};
    int         mon_w;

    always @(posedge clk) req_edge <= {readMem1 | writeMem1, readMem0 | writeMem0};

    always @(negedge clk) begin
        if (rst) begin
            skip[0] = 0;
            skip[1] = 0;
        end else begin
            check("pulse_excl", 32'({memReady0 & busError0, memReady1 & busError1}), 0);
            check("pulse_owner", 32'(((memReady0 | busError0) & ~grant[0]) |
                                     ((memReady1 | busError1) & ~grant[1])), 0);
            check("grant_onehot", 32'(grant == 2'b11), 0);
            check("busy_vs_grant", 32'(busy), 32'(grant != 2'b00));
            check("strobe_excl", 32'(readmem & writemem), 0);
            if (readmem || writemem) begin
                check("strobe_owned", 32'(grant == 2'b01 || grant == 2'b10), 1);
                if (grant == 2'b01) begin
                    check("mux_addr0", addressBus, address0);
                    check("mux_dir0", 32'(writemem), 32'(writeMem0));
                    if (writemem) check("mux_wdata0", 32'(memDataOut), 32'(dataIn0));
                end
                if (grant == 2'b10) begin
                    check("mux_addr1", addressBus, address1);
                    check("mux_dir1", 32'(writemem), 32'(writeMem1));
                    if (writemem) check("mux_wdata1", 32'(memDataOut), 32'(dataIn1));
                end
            end
            // A port that was already requesting at a grant edge may see at
            // most one grant go to the other port.
            if (grant != 2'b00 && mon_prev_grant == 2'b00) begin
                mon_w = grant[1] ? 1 : 0;
                skip[mon_w] = 0;
                if (req_edge[1-mon_w]) begin
                    skip[1-mon_w]++;
                    check("rr_fair", 32'(skip[1-mon_w] <= 1), 1);
                end else begin
                    skip[1-mon_w] = 0;
                end
            end
        end
        mon_prev_grant = grant;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic drive_port(input int p, input bit rd, input bit wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            readMem0 = rd; writeMem0 = wr; address0 = a; dataIn0 = d;
        end else begin
            readMem1 = rd; writeMem1 = wr; address1 = a; dataIn1 = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_port(0, 0, 0, '0, '0);
        drive_port(1, 0, 0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_dout[0] = '0;
        exp_dout[1] = '0;
    endtask

    // One complete transaction on port p, checked against the reference model.
    task automatic run_txn(input int p, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        int            n;
        bit            got_rdy;
        bit            got_err;
        logic [DW-1:0] dout;
        @(negedge clk);
        drive_port(p, rd, wr, a, d);
        got_rdy = 0;
        got_err = 0;
        n = 0;
        while (!got_rdy && !got_err && n < 200) begin
            @(negedge clk);
            n++;
            got_rdy = (p == 0) ? memReady0 : memReady1;
            got_err = (p == 0) ? busError0 : busError1;
        end
        dout = (p == 0) ? dataOut0 : dataOut1;
        drive_port(p, 0, 0, a, d);
        check($sformatf("txn_bound_p%0d", p), 32'(got_rdy | got_err), 1);
        if (a < 32'd256) begin
            check($sformatf("txn_ready_p%0d_a%0h", p, a), 32'(got_rdy), 1);
            check($sformatf("txn_noerr_p%0d_a%0h", p, a), 32'(got_err), 0);
            if (got_rdy) begin
                if (wr) ref_mem[a[7:0]] = d;
                else    exp_dout[p] = ref_mem[a[7:0]];
            end
        end else begin
            check($sformatf("txn_err_p%0d_a%0h", p, a), 32'(got_err), 1);
            check($sformatf("txn_nordy_p%0d_a%0h", p, a), 32'(got_rdy), 0);
        end
        check($sformatf("txn_dout_p%0d", p), 32'(dout), 32'(exp_dout[p]));
    endtask

    task automatic rand_driver(input int p, input int count);
        bit            wr;
        bit            rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < count; i++) begin
            wr = 1'($urandom_range(0, 1));
            rd = !wr || ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
            else                           a = 32'($urandom_range(0, 15));
            d = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn(p, rd, wr, a, d);
        end
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int         n;
        int         r0;
        int         r1;
        bit         saw_rdy;
        logic [1:0] prev;
        logic [1:0] gq [$];

        rst = 1'b0;
        drive_port(0, 0, 0, '0, '0);
        drive_port(1, 0, 0, '0, '0);
        for (int i = 0; i < 256; i++) begin
            seg_mem[i] = init_val(i);
            ref_mem[i] = init_val(i);
        end
        exp_dout[0] = '0;
        exp_dout[1] = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_dataout", 32'({dataOut1, dataOut0}), 0);
        check("rst_addr", addressBus, 0);
        check("rst_wdata", 32'(memDataOut), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_strobes", 32'({readmem, writemem}), 0);
        check("rst_pulses", 32'({memReady0, memReady1, busError0, busError1}), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        // Single read, zero-wait: strobe after k, ready after k+1, idle after k+2
        drive_port(0, 1, 0, 32'h10, 8'h00);
        @(negedge clk);
        check("rd_strobe", 32'({readmem, writemem}), 32'b10);
        check("rd_addr", addressBus, 32'h10);
        check("rd_grant", 32'(grant), 32'b01);
        check("rd_busy", 32'(busy), 1);
        check("rd_early_ready", 32'(memReady0), 0);
        @(negedge clk);
        check("rd_strobe_drop", 32'({readmem, writemem}), 0);
        check("rd_ready", 32'(memReady0), 1);
        check("rd_data", 32'(dataOut0), 32'hA5);
        drive_port(0, 0, 0, 32'h10, 8'h00);
        exp_dout[0] = 8'hA5;
        @(negedge clk);
        check("rd_grant_idle", 32'(grant), 0);
        check("rd_busy_idle", 32'(busy), 0);
        check("rd_ready_once", 32'(memReady0), 0);

        // Port 1 write then read back
        drive_port(1, 0, 1, 32'h20, 8'h3C);
        @(negedge clk);
        check("wr_strobe", 32'({readmem, writemem}), 32'b01);
        check("wr_data", 32'(memDataOut), 32'h3C);
        check("wr_grant", 32'(grant), 32'b10);
        @(negedge clk);
        check("wr_ready", 32'(memReady1), 1);
        check("wr_strobe_drop", 32'(writemem), 0);
        drive_port(1, 0, 0, 32'h20, 8'h3C);
        ref_mem[8'h20] = 8'h3C;
        run_txn(1, 1, 0, 32'h20, 8'h00);
        check("wr_readback", 32'(dataOut1), 32'h3C);

        // Continuous requests on both ports after reset: 01,10,01,10
        do_reset();
        drive_port(0, 1, 0, 32'h01, 8'h00);
        drive_port(1, 1, 0, 32'h02, 8'h00);
        prev = 2'b00;
        r0 = 0;
        r1 = 0;
        gq.delete();
        repeat (12) begin
            @(negedge clk);
            if (grant != 2'b00 && prev == 2'b00) gq.push_back(grant);
            prev = grant;
            r0 += int'(memReady0);
            r1 += int'(memReady1);
        end
        drive_port(0, 0, 0, 32'h01, 8'h00);
        drive_port(1, 0, 0, 32'h02, 8'h00);
        check("rr_grants", 32'(gq.size()), 4);
        for (int i = 0; i < gq.size(); i++)
            check($sformatf("rr_order%0d", i), 32'(gq[i]), (i % 2 == 0) ? 32'b01 : 32'b10);
        check("rr_ready0", 32'(r0), 2);
        check("rr_ready1", 32'(r1), 2);
        exp_dout[0] = ref_mem[8'h01];
        exp_dout[1] = ref_mem[8'h02];
        check("rr_data0", 32'(dataOut0), 32'(exp_dout[0]));
        check("rr_data1", 32'(dataOut1), 32'(exp_dout[1]));
        @(negedge clk);

        // Unselected address: busError0 after TO access cycles, then port 1 is served
        drive_port(0, 1, 0, 32'h1000, 8'h00);
        @(negedge clk);
        check("to_grant", 32'(grant), 32'b01);
        drive_port(1, 1, 0, 32'h30, 8'h00);
        n = 0;
        saw_rdy = 0;
        while (!busError0 && n < 40) begin
            @(negedge clk);
            n++;
            saw_rdy |= memReady0;
        end
        drive_port(0, 0, 0, 32'h1000, 8'h00);
        check("to_cycles", 32'(n), TO);
        check("to_no_ready", 32'(saw_rdy), 0);
        check("to_dout_kept", 32'(dataOut0), 32'(exp_dout[0]));
        n = 0;
        while (!memReady1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to_next_served", 32'(memReady1), 1);
        check("to_next_data", 32'(dataOut1), 32'(ref_mem[8'h30]));
        exp_dout[1] = ref_mem[8'h30];
        drive_port(1, 0, 0, 32'h30, 8'h00);

        // Read and write both high is a write
        @(negedge clk);
        drive_port(0, 1, 1, 32'h40, 8'h77);
        @(negedge clk);
        check("rw_strobe", 32'({readmem, writemem}), 32'b01);
        check("rw_data", 32'(memDataOut), 32'h77);
        @(negedge clk);
        check("rw_ready", 32'(memReady0), 1);
        check("rw_dout_kept", 32'(dataOut0), 32'(exp_dout[0]));
        drive_port(0, 0, 0, 32'h40, 8'h77);
        ref_mem[8'h40] = 8'h77;
        run_txn(0, 1, 0, 32'h40, 8'h00);

        // Reset during ACCESS aborts at once with no pulses
        max_wait = 8;
        @(negedge clk);
        drive_port(0, 1, 0, 32'h50, 8'h00);
        @(negedge clk);
        check("ra_strobe", 32'(readmem), 1);
        #2 rst = 1'b1;
        #1;
        check("ra_async_strobe", 32'({readmem, writemem}), 0);
        check("ra_async_grant", 32'(grant), 0);
        check("ra_async_busy", 32'(busy), 0);
        check("ra_async_pulses", 32'({memReady0, busError0}), 0);
        @(negedge clk);
        check("ra_held_pulses", 32'({memReady0, busError0, memReady1, busError1}), 0);
        max_wait = 0;
        drive_port(0, 1, 0, 32'h51, 8'h00);
        drive_port(1, 1, 0, 32'h52, 8'h00);
        rst = 1'b0;
        exp_dout[0] = '0;
        exp_dout[1] = '0;
        @(negedge clk);
        check("ra_first_tie", 32'(grant), 32'b01);
        r0 = 0;
        r1 = 0;
        repeat (5) begin
            @(negedge clk);
            r0 += int'(memReady0);
            r1 += int'(memReady1);
        end
        drive_port(0, 0, 0, 32'h51, 8'h00);
        drive_port(1, 0, 0, 32'h52, 8'h00);
        check("ra_after_ready0", 32'(r0), 1);
        check("ra_after_ready1", 32'(r1), 1);
        exp_dout[0] = ref_mem[8'h51];
        exp_dout[1] = ref_mem[8'h52];
        check("ra_after_data0", 32'(dataOut0), 32'(exp_dout[0]));

        // Ready stuck high: RELEASE is forced out after TO cycles, one service only
        @(negedge clk);
        stuck_ready = 1'b1;
        drive_port(1, 0, 1, 32'h60, 8'h11);
        @(negedge clk);
        check("rel_grant", 32'(grant), 32'b10);
        n = 1;
        r1 = 0;
        while (n < 60) begin
            @(negedge clk);
            if (memReady1) begin
                r1++;
                drive_port(1, 0, 0, 32'h60, 8'h11);
            end
            if (!busy) break;
            n++;
        end
        stuck_ready = 1'b0;
        ref_mem[8'h60] = 8'h11;
        check("rel_busy_cycles", 32'(n), TO + 1);
        check("rel_single_ready", 32'(r1), 1);
        run_txn(0, 1, 0, 32'h60, 8'h00);

        // Random traffic from both ports
        max_wait = 3;
        fork
            rand_driver(0, 60);
            rand_driver(1, 60);
        join
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish before 600000");
        $fatal(1, "watchdog expired");
    end

endmodule
